// File: rtl/block_row_store_if.sv
// block_row_store_if
// Bundles the painter-facing signals of the brick-field store.
//   slave  : the store (consumes strobes/row data, drives row view and status)
//   master : the painter/controller side (drives strobes/row data)
// Signals:
//   new_frame, next_line, wr_en, wr_row, start_level   painter -> store
//   line_state, busy, blocks_left, level_cleared, score store -> painter
interface block_row_store_if #(
  parameter int BLOCKS_PER_ROW = 13,
  parameter int CNT_W          = 8
);
  logic                      new_frame;
  logic                      next_line;
  logic                      wr_en;
  logic [BLOCKS_PER_ROW-1:0] wr_row;
  logic                      start_level;
  logic [BLOCKS_PER_ROW-1:0] line_state;
  logic                      busy;
  logic [CNT_W-1:0]          blocks_left;
  logic                      level_cleared;
  logic [11:0]               score;

  modport slave (
    input  new_frame, next_line, wr_en, wr_row, start_level,
    output line_state, busy, blocks_left, level_cleared, score
  );

  modport master (
    output new_frame, next_line, wr_en, wr_row, start_level,
    input  line_state, busy, blocks_left, level_cleared, score
  );
endinterface

// File: rtl/block_row_store.sv
// block_row_store
// Breakout brick field: NUM_ROWS rows of BLOCKS_PER_ROW presence bits.
// Presents rows[row_idx] to the painter, merges the painter's collision
// updates (bits can only clear), counts remaining blocks, refills the field
// on start_level and flags level clear.
// Ports:
//   clk, nRst  clock, asynchronous active-low reset
//   bus        block_row_store_if.slave (strobes, wr_row, line_state, status)
// Optional feature: define BLOCK_ROW_STORE_SCORE_EN to build a saturating
// 12-bit destroyed-block score; otherwise score is tied to zero.
module block_row_store #(
  parameter int BLOCKS_PER_ROW = 13,
  parameter int NUM_ROWS       = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             nRst,
  block_row_store_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ROWS);
  localparam int POP_W = $clog2(BLOCKS_PER_ROW + 1);

  typedef enum logic [1:0] {INIT, PLAY, CLEARED} state_t;

  state_t                                        state_q, state_d;
  logic [NUM_ROWS-1:0][BLOCKS_PER_ROW-1:0]       rows_q, rows_d;
  logic [IDX_W-1:0]                              row_idx_q, row_idx_d;
  logic [IDX_W-1:0]                              fill_idx_q, fill_idx_d;
  logic [CNT_W-1:0]                              blocks_left_q, blocks_left_d;

  logic [BLOCKS_PER_ROW-1:0] cur_row;
  logic [POP_W-1:0]          removed;
  logic                      wr_acc;

  function automatic logic [POP_W-1:0] popcount(input logic [BLOCKS_PER_ROW-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < BLOCKS_PER_ROW; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

  assign cur_row = rows_q[row_idx_q];
  // Blocks present now but absent in the painter's row are the ones destroyed.
  assign removed = popcount(cur_row & ~bus.wr_row);
  // The fill owns the array during INIT, so painter writes are dropped there.
  assign wr_acc  = bus.wr_en && (state_q != INIT);

  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    row_idx_d     = row_idx_q;
    fill_idx_d    = fill_idx_q;
    blocks_left_d = blocks_left_q;

    case (state_q)
      INIT: begin
        rows_d[fill_idx_q] = '1;
        if (fill_idx_q == IDX_W'(NUM_ROWS - 1)) begin
          blocks_left_d = CNT_W'(NUM_ROWS * BLOCKS_PER_ROW);
          fill_idx_d    = '0;
          state_d       = PLAY;
        end else begin
          fill_idx_d = fill_idx_q + IDX_W'(1);
        end
      end
      PLAY:    if (blocks_left_q == '0) state_d = CLEARED;
      default: ;
    endcase

    // AND-merge: a set bit from the painter can never revive a block.
    if (wr_acc) begin
      rows_d[row_idx_q] = cur_row & bus.wr_row;
      blocks_left_d     = blocks_left_q - CNT_W'(removed);
    end

    if (bus.start_level) begin
      state_d    = INIT;
      fill_idx_d = '0;
    end

    // Write above used the old index; new_frame beats next_line.
    if (bus.new_frame)
      row_idx_d = '0;
    else if (bus.next_line)
      row_idx_d = (row_idx_q == IDX_W'(NUM_ROWS - 1)) ? '0 : row_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= INIT;
      rows_q        <= '0;
      row_idx_q     <= '0;
      fill_idx_q    <= '0;
      blocks_left_q <= '0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      row_idx_q     <= row_idx_d;
      fill_idx_q    <= fill_idx_d;
      blocks_left_q <= blocks_left_d;
    end
  end

`ifdef BLOCK_ROW_STORE_SCORE_EN
  logic [11:0] score_q, score_d;
  logic [12:0] score_sum;

  assign score_sum = {1'b0, score_q} + 13'(removed);

  always_comb begin
    score_d = score_q;
    if (wr_acc) score_d = score_sum[12] ? 12'hFFF : score_sum[11:0];
  end

  // Survives start_level on purpose: only nRst clears the score.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) score_q <= '0;
    else       score_q <= score_d;
  end

  assign bus.score = score_q;
`else
  assign bus.score = 12'd0;
`endif

  assign bus.line_state    = cur_row;
  assign bus.busy          = (state_q == INIT);
  assign bus.blocks_left   = blocks_left_q;
  assign bus.level_cleared = (state_q == CLEARED);
endmodule

// File: tb/tb_block_row_store.sv
module tb_block_row_store;
  localparam int          NR   = 16;
  localparam logic [12:0] FULL = 13'h1FFF;
`ifdef BLOCK_ROW_STORE_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  block_row_store_if #(.BLOCKS_PER_ROW(13), .CNT_W(8)) bus ();

  block_row_store #(.BLOCKS_PER_ROW(13), .NUM_ROWS(NR), .CNT_W(8)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: the field as an array of rows, the painter's view index
  // and the running score; remaining blocks are recounted from the field.
  logic [12:0] mrows [NR];
  int          midx;
  int          mscore;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_left();
    int s = 0;
    for (int i = 0; i < NR; i++) s += $countones(mrows[i]);
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < NR; i++) mrows[i] = FULL;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".line_state"},  32'(bus.line_state),  32'(mrows[midx]));
    check({tag, ".blocks_left"}, 32'(bus.blocks_left), 32'(model_left()));
    check({tag, ".score"},       32'(bus.score),       32'(mscore));
  endtask

  // One clock with the given strobes (field in PLAY/CLEARED), model updated alongside.
  task automatic step(input bit we, input logic [12:0] wr, input bit nl, input bit nf);
    int removed;
    bus.wr_en = we; bus.wr_row = wr; bus.next_line = nl; bus.new_frame = nf;
    if (we) begin
      removed = $countones(mrows[midx] & ~wr);
      check("no_underflow", 32'(removed <= int'(bus.blocks_left)), 32'd1);
      mrows[midx] = mrows[midx] & wr;
      if (SCORE_EN) mscore = (mscore + removed > 4095) ? 4095 : mscore + removed;
    end
    if (nf)      midx = 0;
    else if (nl) midx = (midx + 1) % NR;
    cyc();
    bus.wr_en = 1'b0; bus.next_line = 1'b0; bus.new_frame = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
  endtask

  task automatic wait_fill(input string tag);
    int n;
    count_busy(n);
    check({tag, ".busy_cycles"}, 32'(n), 32'd16);
    model_fill();
    check_model(tag);
    check({tag, ".level_cleared"}, 32'(bus.level_cleared), 32'd0);
  endtask

  task automatic start_level();
    bus.start_level = 1'b1;
    cyc();
    bus.start_level = 1'b0;
  endtask

  // Resync, then zero every row while advancing (write hits old index each time).
  task automatic clear_field(input string tag);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int r = 0; r < NR; r++) step(1'b1, 13'h0, 1'b1, 1'b0);
    check_model(tag);
    check({tag, ".lc_same_cycle"}, 32'(bus.level_cleared), 32'd0);
    cyc();
    check({tag, ".lc_next_cycle"}, 32'(bus.level_cleared), 32'd1);
  endtask

  initial begin
    logic [12:0] r;
    bus.new_frame = 1'b0; bus.next_line = 1'b0; bus.wr_en = 1'b0;
    bus.wr_row = '0; bus.start_level = 1'b0;
    for (int i = 0; i < NR; i++) mrows[i] = '0;
    midx = 0; mscore = 0;

    // Reset state
    cyc(); cyc();
    check_model("reset");
    check("reset.busy", 32'(bus.busy), 32'd1);
    check("reset.level_cleared", 32'(bus.level_cleared), 32'd0);

    nRst = 1'b1;
    wait_fill("init");

    // Hit and revive attempt on row 0
    step(1'b1, 13'h1FFE, 1'b0, 1'b0);
    check_model("hit");
    step(1'b1, FULL, 1'b0, 1'b0);
    check_model("revive");

    // Painter timing: write at t, next_line at t+1, next row visible at t+2
    r = 13'($urandom) & FULL;
    step(1'b1, r, 1'b0, 1'b0);
    check("painter.written", 32'(bus.line_state), 32'(mrows[0]));
    step(1'b0, '0, 1'b1, 1'b0);
    check_model("painter.next");

    // 17 advances from row 0 wrap to row 1
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("wrap.idx", 32'(midx), 32'd1);
    check_model("wrap");

    // Simultaneous strobes at row 5
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    check_model("nf_nl");
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 13'($urandom) & FULL, 1'b0, 1'b1);
    check_model("wr_nf");
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_model("wr_nf.row5");

    // Randomized play
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 2) == 0, 13'($urandom | $urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      check_model("rand");
    end

    // Clear the level, writes in CLEARED change nothing
    clear_field("clear");
    step(1'b1, 13'h0, 1'b0, 1'b0);
    check_model("cleared.write");
    check("cleared.stay", 32'(bus.level_cleared), 32'd1);

    // New level keeps score
    start_level();
    wait_fill("relevel");

    // start_level during INIT restarts the fill
    start_level();
    cyc(); cyc(); cyc(); cyc(); cyc();
    start_level();
    wait_fill("restart");

    // Drive the score into saturation over many cleared levels
    clear_field("sat0");
    for (int l = 0; l < 18; l++) begin
      start_level();
      wait_fill("satlvl");
      clear_field("satclr");
    end
    check("sat.score", 32'(bus.score), SCORE_EN ? 32'd4095 : 32'd0);

    // Reset during PLAY
    start_level();
    wait_fill("prereset");
    step(1'b1, 13'h0F0F, 1'b1, 1'b0);
    nRst = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mrows[i] = '0;
    midx = 0; mscore = 0;
    check_model("midreset");
    check("midreset.busy", 32'(bus.busy), 32'd1);
    cyc();
    nRst = 1'b1;
    wait_fill("postreset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
